// File: rtl/bf_mem_arbiter.sv
// bf_mem_arbiter: round-robin arbiter for the BF core's single-port data RAM.
// Defining BF_MEM_ARB_LOCK_EN enables the requester bus lock for atomic read-modify-write.
module bf_mem_arbiter #(
  parameter int ADDR_WIDTH   = 16,
  parameter int DATA_WIDTH   = 8,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_0,
  input  logic                  we_0,
  input  logic [ADDR_WIDTH-1:0] addr_0,
  input  logic [DATA_WIDTH-1:0] wdata_0,
  input  logic                  lock_0,
  output logic                  ack_0,
  output logic                  rvalid_0,
  input  logic                  req_1,
  input  logic                  we_1,
  input  logic [ADDR_WIDTH-1:0] addr_1,
  input  logic [DATA_WIDTH-1:0] wdata_1,
  input  logic                  lock_1,
  output logic                  ack_1,
  output logic                  rvalid_1,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  ram_en,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t                r_state;
  state_t                w_nextState;
  logic                  r_lastGrant;
  logic                  r_winner;
  logic [2:0]            r_cnt;
  logic                  r_ack0;
  logic                  r_ack1;
  logic                  r_rvalid0;
  logic                  r_rvalid1;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  r_ramEn;
  logic                  r_ramWe;
  logic [ADDR_WIDTH-1:0] r_ramAddr;
  logic [DATA_WIDTH-1:0] r_ramWdata;

  logic w_req0;
  logic w_req1;
  logic w_grantValid;
  logic w_grantSel;
  logic w_lockActive;
  logic w_capture;

`ifdef BF_MEM_ARB_LOCK_EN
  logic r_ownerValid;
  logic r_owner;

  // The owner keeps the bus only while it still drives its lock in IDLE.
  assign w_lockActive = r_ownerValid && (r_owner ? lock_1 : lock_0);
  assign w_req0       = req_0 && !(w_lockActive && r_owner);
  assign w_req1       = req_1 && !(w_lockActive && !r_owner);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ownerValid <= 1'b0;
      r_owner      <= 1'b0;
    end else begin
      if (r_state == IDLE && r_ownerValid && !w_lockActive)
        r_ownerValid <= 1'b0;
      if (w_grantValid && (w_grantSel ? lock_1 : lock_0)) begin
        r_ownerValid <= 1'b1;
        r_owner      <= w_grantSel;
      end
    end
  end
`else
  logic w_unusedLock;

  assign w_unusedLock = lock_0 | lock_1;
  assign w_lockActive = 1'b0;
  assign w_req0       = req_0;
  assign w_req1       = req_1;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_state <= IDLE;
    else
      r_state <= w_nextState;
  end

  always_comb begin
    w_nextState  = r_state;
    w_grantValid = 1'b0;
    w_grantSel   = 1'b0;
    w_capture    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_req0 && w_req1) begin
          w_grantValid = 1'b1;
          w_grantSel   = ~r_lastGrant;
        end else if (w_req0) begin
          w_grantValid = 1'b1;
          w_grantSel   = 1'b0;
        end else if (w_req1) begin
          w_grantValid = 1'b1;
          w_grantSel   = 1'b1;
        end
        if (w_grantValid)
          w_nextState = ISSUE;
      end
      ISSUE: begin
        if (r_ramWe) begin
          w_nextState = IDLE;
        end else if (READ_LATENCY == 1) begin
          w_capture   = 1'b1;
          w_nextState = IDLE;
        end else begin
          w_nextState = WAIT;
        end
      end
      WAIT: begin
        if (r_cnt == 3'd1) begin
          w_capture   = 1'b1;
          w_nextState = IDLE;
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  // Command strobes and acks are one-cycle pulses; address and data hold until the next grant.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_lastGrant <= 1'b1;
      r_winner    <= 1'b0;
      r_cnt       <= 3'd0;
      r_ack0      <= 1'b0;
      r_ack1      <= 1'b0;
      r_rvalid0   <= 1'b0;
      r_rvalid1   <= 1'b0;
      r_rdata     <= '0;
      r_ramEn     <= 1'b0;
      r_ramWe     <= 1'b0;
      r_ramAddr   <= '0;
      r_ramWdata  <= '0;
    end else begin
      r_ack0    <= 1'b0;
      r_ack1    <= 1'b0;
      r_rvalid0 <= 1'b0;
      r_rvalid1 <= 1'b0;
      r_ramEn   <= 1'b0;
      r_ramWe   <= 1'b0;
      if (w_grantValid) begin
        r_ramEn    <= 1'b1;
        r_ramWe    <= w_grantSel ? we_1 : we_0;
        r_ramAddr  <= w_grantSel ? addr_1 : addr_0;
        r_ramWdata <= w_grantSel ? wdata_1 : wdata_0;
        r_ack0     <= ~w_grantSel;
        r_ack1     <= w_grantSel;
        r_winner   <= w_grantSel;
        if (!w_lockActive)
          r_lastGrant <= w_grantSel;
      end
      if (r_state == ISSUE && w_nextState == WAIT)
        r_cnt <= 3'(READ_LATENCY - 1);
      else if (r_state == WAIT)
        r_cnt <= r_cnt - 3'd1;
      if (w_capture) begin
        r_rdata   <= ram_rdata;
        r_rvalid0 <= ~r_winner;
        r_rvalid1 <= r_winner;
      end
    end
  end

  assign ack_0     = r_ack0;
  assign ack_1     = r_ack1;
  assign rvalid_0  = r_rvalid0;
  assign rvalid_1  = r_rvalid1;
  assign rdata     = r_rdata;
  assign ram_en    = r_ramEn;
  assign ram_we    = r_ramWe;
  assign ram_addr  = r_ramAddr;
  assign ram_wdata = r_ramWdata;

endmodule

// File: tb/tb_bf_mem_arbiter.sv
// Self-checking bench for bf_mem_arbiter: cycle vector table on a READ_LATENCY=1 instance,
// plus latency and mid-read reset sequences on a READ_LATENCY=3 instance.
module tb_bf_mem_arbiter;

  typedef struct packed {
    logic        req;
    logic        we;
    logic        lock;
    logic [15:0] addr;
    logic [7:0]  wdata;
  } cmd_t;

  typedef struct {
    cmd_t        c0;
    cmd_t        c1;
    logic [29:0] expOut;
    logic [1:0]  push;
    logic [7:0]  pushData;
  } vec_t;

  typedef struct {
    logic       who;
    logic [7:0] data;
  } rd_t;

  int checks   = 0;
  int failures = 0;

  logic clk  = 1'b0;
  logic rst1 = 1'b1;
  logic rst3 = 1'b1;

  always #5 clk = ~clk;

  logic        aReq0 = 0, aWe0 = 0, aLock0 = 0, aReq1 = 0, aWe1 = 0, aLock1 = 0;
  logic [15:0] aAddr0 = 0, aAddr1 = 0;
  logic [7:0]  aWdata0 = 0, aWdata1 = 0;
  logic        aAck0, aAck1, aRvalid0, aRvalid1, aRamEn, aRamWe;
  logic [7:0]  aRdata, aRamWdata, aRamRdata;
  logic [15:0] aRamAddr;

  logic        bReq0 = 0, bWe0 = 0, bLock0 = 0, bReq1 = 0, bWe1 = 0, bLock1 = 0;
  logic [15:0] bAddr0 = 0, bAddr1 = 0;
  logic [7:0]  bWdata0 = 0, bWdata1 = 0;
  logic        bAck0, bAck1, bRvalid0, bRvalid1, bRamEn, bRamWe;
  logic [7:0]  bRdata, bRamWdata, bRamRdata;
  logic [15:0] bRamAddr;

  function automatic logic [7:0] romVal(input logic [15:0] a);
    case (a)
      16'h0010: return 8'h5A;
      16'h0011: return 8'h5C;
      16'h0020: return 8'h33;
      default:  return a[7:0] ^ 8'hA5;
    endcase
  endfunction

  // Instance A has a one-cycle RAM: data follows the address during the ram_en cycle.
  assign aRamRdata = romVal(aRamAddr);

  // Instance B's RAM returns data two cycles after ram_en, garbage otherwise.
  logic       bV1 = 0, bV2 = 0;
  logic [7:0] bP1 = 0, bP2 = 0;
  always @(posedge clk) begin
    bV1 <= bRamEn && !bRamWe;
    bP1 <= romVal(bRamAddr);
    bV2 <= bV1;
    bP2 <= bP1;
  end
  assign bRamRdata = bV2 ? bP2 : 8'hEE;

  bf_mem_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(8), .READ_LATENCY(1)) dutA (
    .clk(clk), .reset(rst1),
    .req_0(aReq0), .we_0(aWe0), .addr_0(aAddr0), .wdata_0(aWdata0), .lock_0(aLock0),
    .ack_0(aAck0), .rvalid_0(aRvalid0),
    .req_1(aReq1), .we_1(aWe1), .addr_1(aAddr1), .wdata_1(aWdata1), .lock_1(aLock1),
    .ack_1(aAck1), .rvalid_1(aRvalid1),
    .rdata(aRdata), .ram_en(aRamEn), .ram_we(aRamWe), .ram_addr(aRamAddr),
    .ram_wdata(aRamWdata), .ram_rdata(aRamRdata)
  );

  bf_mem_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(8), .READ_LATENCY(3)) dutB (
    .clk(clk), .reset(rst3),
    .req_0(bReq0), .we_0(bWe0), .addr_0(bAddr0), .wdata_0(bWdata0), .lock_0(bLock0),
    .ack_0(bAck0), .rvalid_0(bRvalid0),
    .req_1(bReq1), .we_1(bWe1), .addr_1(bAddr1), .wdata_1(bWdata1), .lock_1(bLock1),
    .ack_1(bAck1), .rvalid_1(bRvalid1),
    .rdata(bRdata), .ram_en(bRamEn), .ram_we(bRamWe), .ram_addr(bRamAddr),
    .ram_wdata(bRamWdata), .ram_rdata(bRamRdata)
  );

  rd_t qA[$];
  rd_t qB[$];
  rd_t expA, expB;

  // Scoreboard: every rvalid must match the oldest outstanding read of that instance.
  always @(negedge clk) begin
    if (aRvalid0 || aRvalid1) begin
      checks++;
      if (qA.size() == 0) begin
        failures++;
        $display("[TB] FAIL rdA unexpected rvalid0=%0b rvalid1=%0b rdata=%h", aRvalid0, aRvalid1, aRdata);
      end else begin
        expA = qA.pop_front();
        if (aRvalid1 !== expA.who || aRvalid0 !== !expA.who || aRdata !== expA.data) begin
          failures++;
          $display("[TB] FAIL rdA actual rv1=%0b rv0=%0b rdata=%h required who=%0b rdata=%h",
                   aRvalid1, aRvalid0, aRdata, expA.who, expA.data);
        end
      end
    end
    if (bRvalid0 || bRvalid1) begin
      checks++;
      if (qB.size() == 0) begin
        failures++;
        $display("[TB] FAIL rdB unexpected rvalid0=%0b rvalid1=%0b rdata=%h", bRvalid0, bRvalid1, bRdata);
      end else begin
        expB = qB.pop_front();
        if (bRvalid1 !== expB.who || bRvalid0 !== !expB.who || bRdata !== expB.data) begin
          failures++;
          $display("[TB] FAIL rdB actual rv1=%0b rv0=%0b rdata=%h required who=%0b rdata=%h",
                   bRvalid1, bRvalid0, bRdata, expB.who, expB.data);
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    {aReq0, aWe0, aLock0, aAddr0, aWdata0} = v.c0;
    {aReq1, aWe1, aLock1, aAddr1, aWdata1} = v.c1;
    if (v.push != 2'd0) qA.push_back('{who: (v.push == 2'd2), data: v.pushData});
  endtask

  function automatic cmd_t mkCmd(input logic req, input logic we, input logic lock,
                                 input logic [15:0] a, input logic [7:0] d);
    cmd_t c;
    c.req = req; c.we = we; c.lock = lock; c.addr = a; c.wdata = d;
    return c;
  endfunction

  // ack and rv are {requester1, requester0}; push is 1 for a requester-0 read, 2 for requester 1.
  function automatic vec_t mkVec(input cmd_t c0, input cmd_t c1, input logic [1:0] ack,
                                 input logic [1:0] rv, input logic en, input logic we,
                                 input logic [15:0] a, input logic [7:0] d,
                                 input logic [1:0] push, input logic [7:0] pd);
    vec_t v;
    v.c0 = c0; v.c1 = c1;
    v.expOut = {ack, rv, en, we, a, d};
    v.push = push; v.pushData = pd;
    return v;
  endfunction

  function automatic logic [29:0] outA();
    return {aAck1, aAck0, aRvalid1, aRvalid0, aRamEn, aRamWe, aRamAddr, aRamWdata};
  endfunction

  function automatic logic [37:0] outB();
    return {bAck1, bAck0, bRvalid1, bRvalid0, bRamEn, bRamWe, bRamAddr, bRamWdata, bRdata};
  endfunction

  vec_t vecs[$];
  cmd_t nop, rd10, wr03, wr30, wr31, rd20L, wr20L, wr20, wr40, lockOnly;

  initial begin
    nop      = mkCmd(0, 0, 0, 16'h0000, 8'h00);
    rd10     = mkCmd(1, 0, 0, 16'h0010, 8'h00);
    wr03     = mkCmd(1, 1, 0, 16'h0003, 8'h41);
    wr30     = mkCmd(1, 1, 0, 16'h0030, 8'hA0);
    wr31     = mkCmd(1, 1, 0, 16'h0031, 8'hB1);
    rd20L    = mkCmd(1, 0, 1, 16'h0020, 8'h00);
    wr20L    = mkCmd(1, 1, 1, 16'h0020, 8'h34);
    wr20     = mkCmd(1, 1, 0, 16'h0020, 8'h34);
    wr40     = mkCmd(1, 1, 0, 16'h0040, 8'h77);
    lockOnly = mkCmd(0, 0, 1, 16'h0000, 8'h00);

    vecs.push_back(mkVec(rd10, nop,  2'b00, 2'b00, 0, 0, 16'h0000, 8'h00, 2'd1, 8'h5A));
    vecs.push_back(mkVec(rd10, nop,  2'b01, 2'b00, 1, 0, 16'h0010, 8'h00, 2'd0, 8'h00));
    vecs.push_back(mkVec(nop,  nop,  2'b00, 2'b01, 0, 0, 16'h0010, 8'h00, 2'd0, 8'h00));
    vecs.push_back(mkVec(nop,  wr03, 2'b00, 2'b00, 0, 0, 16'h0010, 8'h00, 2'd0, 8'h00));
    vecs.push_back(mkVec(nop,  wr03, 2'b10, 2'b00, 1, 1, 16'h0003, 8'h41, 2'd0, 8'h00));
    vecs.push_back(mkVec(nop,  nop,  2'b00, 2'b00, 0, 0, 16'h0003, 8'h41, 2'd0, 8'h00));
    vecs.push_back(mkVec(nop,  nop,  2'b00, 2'b00, 0, 0, 16'h0003, 8'h41, 2'd0, 8'h00));
    vecs.push_back(mkVec(wr30, wr31, 2'b00, 2'b00, 0, 0, 16'h0003, 8'h41, 2'd0, 8'h00));
    vecs.push_back(mkVec(wr30, wr31, 2'b01, 2'b00, 1, 1, 16'h0030, 8'hA0, 2'd0, 8'h00));
    vecs.push_back(mkVec(wr30, wr31, 2'b00, 2'b00, 0, 0, 16'h0030, 8'hA0, 2'd0, 8'h00));
    vecs.push_back(mkVec(wr30, wr31, 2'b10, 2'b00, 1, 1, 16'h0031, 8'hB1, 2'd0, 8'h00));
    vecs.push_back(mkVec(wr30, wr31, 2'b00, 2'b00, 0, 0, 16'h0031, 8'hB1, 2'd0, 8'h00));
    vecs.push_back(mkVec(wr30, wr31, 2'b01, 2'b00, 1, 1, 16'h0030, 8'hA0, 2'd0, 8'h00));
    vecs.push_back(mkVec(wr30, wr31, 2'b00, 2'b00, 0, 0, 16'h0030, 8'hA0, 2'd0, 8'h00));
    vecs.push_back(mkVec(wr30, wr31, 2'b10, 2'b00, 1, 1, 16'h0031, 8'hB1, 2'd0, 8'h00));
    vecs.push_back(mkVec(rd20L, wr40, 2'b00, 2'b00, 0, 0, 16'h0031, 8'hB1, 2'd1, 8'h33));
    vecs.push_back(mkVec(rd20L, wr40, 2'b01, 2'b00, 1, 0, 16'h0020, 8'h00, 2'd0, 8'h00));
    vecs.push_back(mkVec(wr20L, wr40, 2'b00, 2'b01, 0, 0, 16'h0020, 8'h00, 2'd0, 8'h00));
`ifdef BF_MEM_ARB_LOCK_EN
    vecs.push_back(mkVec(wr20L, wr40, 2'b01, 2'b00, 1, 1, 16'h0020, 8'h34, 2'd0, 8'h00));
    vecs.push_back(mkVec(lockOnly, wr40, 2'b00, 2'b00, 0, 0, 16'h0020, 8'h34, 2'd0, 8'h00));
    vecs.push_back(mkVec(nop,  wr40, 2'b00, 2'b00, 0, 0, 16'h0020, 8'h34, 2'd0, 8'h00));
    vecs.push_back(mkVec(nop,  wr40, 2'b10, 2'b00, 1, 1, 16'h0040, 8'h77, 2'd0, 8'h00));
    vecs.push_back(mkVec(nop,  nop,  2'b00, 2'b00, 0, 0, 16'h0040, 8'h77, 2'd0, 8'h00));
`else
    vecs.push_back(mkVec(wr20L, wr40, 2'b10, 2'b00, 1, 1, 16'h0040, 8'h77, 2'd0, 8'h00));
    vecs.push_back(mkVec(wr20L, nop, 2'b00, 2'b00, 0, 0, 16'h0040, 8'h77, 2'd0, 8'h00));
    vecs.push_back(mkVec(wr20, nop,  2'b01, 2'b00, 1, 1, 16'h0020, 8'h34, 2'd0, 8'h00));
    vecs.push_back(mkVec(nop,  nop,  2'b00, 2'b00, 0, 0, 16'h0020, 8'h34, 2'd0, 8'h00));
    vecs.push_back(mkVec(nop,  nop,  2'b00, 2'b00, 0, 0, 16'h0020, 8'h34, 2'd0, 8'h00));
`endif

    // Instance A: reset state, then the cycle table starting the cycle reset is released.
    repeat (2) @(negedge clk);
    #1 checkOutput("resetA", {outA(), aRdata}, 38'd0);
    @(negedge clk);
    rst1 = 1'b0;
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      #1 checkOutput($sformatf("vecA%0d", i), outA(), vecs[i].expOut);
      @(negedge clk);
    end
    checkOutput("qAEmpty", qA.size(), 0);

    // Instance B: READ_LATENCY=3 read from requester 1.
    #1 checkOutput("resetB", outB(), 38'd0);
    @(negedge clk);
    rst3 = 1'b0;
    for (int c = 0; c < 8; c++) begin
      bReq1  = (c < 2);
      bWe1   = 1'b0;
      bAddr1 = 16'h0010;
      if (c == 0) qB.push_back('{who: 1'b1, data: 8'h5A});
      #1 checkOutput($sformatf("latB%0d", c),
                     {bAck1, bAck0, bRvalid1, bRvalid0, bRamEn, bRamWe},
                     {(c == 1), 1'b0, (c == 4), 1'b0, (c == 1), 1'b0});
      @(negedge clk);
    end
    checkOutput("qBEmpty", qB.size(), 0);

    // Instance B: reset asserted while the read sits in WAIT; its result must never appear.
    for (int c = 0; c < 3; c++) begin
      bReq1  = (c < 2);
      bAddr1 = 16'h0011;
      #1 checkOutput($sformatf("midB%0d", c), {bAck1, bRamEn}, {(c == 1), (c == 1)});
      @(negedge clk);
    end
    rst3 = 1'b1;
    #1 checkOutput("midResetB", outB(), 38'd0);
    repeat (2) @(negedge clk);
    rst3 = 1'b0;
    for (int c = 0; c < 6; c++) begin
      #1 checkOutput($sformatf("postResetB%0d", c), outB(), 38'd0);
      @(negedge clk);
    end
    checkOutput("qBEmptyEnd", qB.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
